// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller.
// Takes two raw buttons (start/stop and clear) and drives the seconds-counter
// controls: a count enable, a one-second tick strobe and a one-cycle clear.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE  00 | stopped at zero; the prescaler is held at 0
// RUNNING 01 | counting; the prescaler advances and wraps, and tick fires
// PAUSED 10 | stopped; the prescaler holds, so the fractional second is kept
// 11       | unused; falls back to IDLE
module stopwatch_ctrl #(
  parameter int unsigned CLKS_PER_TICK   = 100000000,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_start_stop,
  input  logic       btn_clear,
  output logic       en,
  output logic       tick,
  output logic       clr,
  output logic [1:0] state
);

  localparam int unsigned PS_W = $clog2(CLKS_PER_TICK);
  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(CLKS_PER_TICK - 1);
  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  state_t          state_q;
  logic [PS_W-1:0] presc;
  logic [1:0]      btn_raw;
  logic [1:0]      press;
  logic            press_start;
  logic            press_clr;

  // Bit 0 is start/stop, bit 1 is clear; both get identical conditioning.
  assign btn_raw = {btn_clear, btn_start_stop};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    logic            sync1;
    logic            sync2;
    logic            db;
    logic            db_d;
    logic [DB_W-1:0] cnt;

    // Two-flop synchronizer for the asynchronous raw button.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1 <= 1'b0;
        sync2 <= 1'b0;
      end else begin
        sync1 <= btn_raw[i];
        sync2 <= sync1;
      end
    end

    // Debounce: accept the new level only after it has disagreed with the
    // debounced level for DEBOUNCE_CYCLES consecutive cycles.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt  <= '0;
        db   <= 1'b0;
        db_d <= 1'b0;
      end else begin
        db_d <= db;
        if (sync2 != db) begin
          if (cnt == DB_MAX) begin
            db  <= sync2;
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    // Rising edge of the debounced level is the press; releases do nothing.
    assign press[i] = db & ~db_d;
  end

  assign press_start = press[0];
  assign press_clr   = press[1];

  // Mode FSM with the prescaler and registered clear pulse. Clear wins over
  // start outside RUNNING; inside RUNNING clear is ignored entirely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      clr     <= 1'b0;
      presc   <= '0;
    end else begin
      clr <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          presc <= '0;
          if (press_clr) begin
            clr <= 1'b1;
          end else if (press_start) begin
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          presc <= (presc == PS_MAX) ? '0 : presc + 1'b1;
          if (press_start) begin
            state_q <= ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          if (press_clr) begin
            state_q <= ST_IDLE;
            clr     <= 1'b1;
            presc   <= '0;
          end else if (press_start) begin
            state_q <= ST_RUN;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          presc   <= '0;
        end
      endcase
    end
  end

  // Outputs decoded from registers only, so reset clears them at once.
  assign en    = (state_q == ST_RUN);
  assign tick  = en && (presc == PS_MAX);
  assign state = state_q;

endmodule
